rc4_key_search_fsm: RTL and testbench

//  Brute-force key-search sequencer for the RC4 cracker. Walks a 22-bit key counter

---
 rtl/rc4_key_search_fsm.sv | 98 +++++++++
 tb/tb_rc4_key_search_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rc4_key_search_fsm.sv
// Brute-force RC4 key-search sequencer: steps a 22-bit key counter across
// [BEGIN_SEARCH, END_SEARCH], launching one check per key and waiting for the verdict.
// Stops on the first valid key (FOUND) or once the range is exhausted (EXHAUSTED).
module rc4_key_search_fsm #(
  parameter logic [21:0] BEGIN_SEARCH = 22'd0,
  parameter logic [21:0] END_SEARCH   = 22'h3FFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Crack_Start,
  input  logic        Key_Valid,
  input  logic        Checker_Finish,
  output logic [23:0] Secret_Key,
  output logic        Check_Ack,
  output logic        Control_Start,
  output logic        Valid_Key_Found,
  output logic [1:0]  LEDR
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT      = 3'd2,
    EVAL      = 3'd3,
    FOUND     = 3'd4,
    EXHAUSTED = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [21:0] key_counter, key_next;
  logic        valid_cap, valid_next;
  logic        control_start_next, check_ack_next, found_next;
  logic [1:0]  ledr_next;

  // The counter is itself a register, so the presented key is glitch-free.
  assign Secret_Key = {2'b00, key_counter};

  // State, key counter, captured verdict and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      key_counter     <= BEGIN_SEARCH;
      valid_cap       <= 1'b0;
      Control_Start   <= 1'b0;
      Check_Ack       <= 1'b0;
      Valid_Key_Found <= 1'b0;
      LEDR            <= 2'b00;
    end else begin
      state           <= state_next;
      key_counter     <= key_next;
      valid_cap       <= valid_next;
      Control_Start   <= control_start_next;
      Check_Ack       <= check_ack_next;
      Valid_Key_Found <= found_next;
      LEDR            <= ledr_next;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they land
  // in the register together with the state they describe.
  always_comb begin
    state_next = state;
    key_next   = key_counter;
    valid_next = valid_cap;
    case (state)
      IDLE:  if (Crack_Start) state_next = START;
      START: state_next = WAIT;
      WAIT: begin
        if (Checker_Finish) begin
          valid_next = Key_Valid;
          state_next = EVAL;
        end
      end
      EVAL: begin
        // A valid verdict takes priority, even on the last key of the range.
        // The >= compare also covers an inverted range (begin above end):
        // only the first key is tried, and the counter never wraps.
        if (valid_cap) begin
          state_next = FOUND;
        end else if (key_counter >= END_SEARCH) begin
          state_next = EXHAUSTED;
        end else begin
          key_next   = key_counter + 22'd1;
          state_next = START;
        end
      end
      FOUND:     state_next = FOUND;
      EXHAUSTED: state_next = EXHAUSTED;
      default:   state_next = IDLE;
    endcase

    control_start_next = (state_next == START);
    check_ack_next     = (state_next == EVAL);
    found_next         = (state_next == FOUND);
    ledr_next          = {state_next == EXHAUSTED, state_next == FOUND};
  end

endmodule

// File: tb/tb_rc4_key_search_fsm.sv
// Directed bench for rc4_key_search_fsm (range 0..5): expected keys are queued
// when a launch is provoked and popped when Control_Start is observed.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rc4_key_search_fsm;

  localparam logic [21:0] END_KEY = 22'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        Crack_Start;
  logic        Key_Valid;
  logic        Checker_Finish;
  logic [23:0] Secret_Key;
  logic        Check_Ack;
  logic        Control_Start;
  logic        Valid_Key_Found;
  logic [1:0]  LEDR;

  int tests = 0;
  int fails = 0;
  int cs_count = 0;
  logic [23:0] exp_keys[$];
  logic [21:0] mk;

  rc4_key_search_fsm #(.BEGIN_SEARCH(22'd0), .END_SEARCH(END_KEY)) dut (
    .clk(clk), .rst(rst), .Crack_Start(Crack_Start), .Key_Valid(Key_Valid),
    .Checker_Finish(Checker_Finish), .Secret_Key(Secret_Key), .Check_Ack(Check_Ack),
    .Control_Start(Control_Start), .Valid_Key_Found(Valid_Key_Found), .LEDR(LEDR)
  );

  always #5 clk = ~clk;

  // Counts cycles in which Control_Start is high.
  always @(posedge clk) if (Control_Start === 1'b1) cs_count++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Control_Start must already be high at this falling edge; key must match queue head.
  task automatic expect_cs(input string tag);
    int n = 0;
    logic [23:0] k;
    while (Control_Start !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, " cs_pulse"}, {31'd0, Control_Start}, 32'd1);
    check({tag, " cs_latency"}, n, 32'd0);
    if (exp_keys.size() == 0) begin
      check({tag, " sb_nonempty"}, 32'd0, 32'd1);
      k = 24'hxxxxxx;
    end else begin
      k = exp_keys.pop_front();
      check({tag, " key"}, {8'd0, Secret_Key}, {8'd0, k});
    end
    @(negedge clk);
    check({tag, " cs_width"}, {31'd0, Control_Start}, 32'd0);
    check({tag, " key_stable"}, {8'd0, Secret_Key}, {8'd0, k});
  endtask

  task automatic start_search(input string tag);
    exp_keys.push_back({2'b00, mk});
    Crack_Start = 1'b1;
    @(negedge clk);
    Crack_Start = 1'b0;
    expect_cs(tag);
  endtask

  // Called in WAIT at a falling edge; ends one cycle after the Check_Ack pulse.
  task automatic do_finish(input string tag, input logic v);
    Checker_Finish = 1'b1;
    Key_Valid      = v;
    @(negedge clk);
    check({tag, " ack_hi"}, {31'd0, Check_Ack}, 32'd1);
    Checker_Finish = 1'b0;
    Key_Valid      = 1'b0;
    if (!v && mk < END_KEY) begin
      mk = mk + 22'd1;
      exp_keys.push_back({2'b00, mk});
    end
    @(negedge clk);
    check({tag, " ack_lo"}, {31'd0, Check_Ack}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    Crack_Start = 1'b0;
    Checker_Finish = 1'b0;
    Key_Valid = 1'b0;
    #1;
    check("async_rst key", {8'd0, Secret_Key}, 32'd0);
    check("async_rst ledr", {30'd0, LEDR}, 32'd0);
    check("async_rst vkf", {31'd0, Valid_Key_Found}, 32'd0);
    exp_keys.delete();
    mk = 22'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int snap;
    rst = 1'b0;
    Crack_Start = 1'b0;
    Checker_Finish = 1'b0;
    Key_Valid = 1'b0;
    mk = 22'd0;

    // 1: reset held, then released with no start
    repeat (3) @(negedge clk);
    check("rst key", {8'd0, Secret_Key}, 32'd0);
    check("rst ledr", {30'd0, LEDR}, 32'd0);
    check("rst cs", {31'd0, Control_Start}, 32'd0);
    check("rst ack", {31'd0, Check_Ack}, 32'd0);
    check("rst vkf", {31'd0, Valid_Key_Found}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle no_cs", cs_count, 32'd0);
    check("idle key", {8'd0, Secret_Key}, 32'd0);

    // Checker_Finish while IDLE is ignored
    Checker_Finish = 1'b1;
    Key_Valid = 1'b1;
    repeat (2) @(negedge clk);
    Checker_Finish = 1'b0;
    Key_Valid = 1'b0;
    @(negedge clk);
    check("idle_fin ack", {31'd0, Check_Ack}, 32'd0);
    check("idle_fin vkf", {31'd0, Valid_Key_Found}, 32'd0);
    check("idle_fin ledr", {30'd0, LEDR}, 32'd0);
    check("idle_fin no_cs", cs_count, 32'd0);

    // 2: start pulse launches key 0
    start_search("start");
    check("start one_pulse", cs_count, 32'd1);

    // 3: three failing verdicts step the key 0->1->2->3
    for (int i = 0; i < 3; i++) begin
      do_finish("fail3", 1'b0);
      expect_cs("step");
    end
    check("step pulses", cs_count, 32'd4);

    // 4: valid verdict on key 3 -> FOUND, frozen
    do_finish("valid", 1'b1);
    check("found vkf", {31'd0, Valid_Key_Found}, 32'd1);
    check("found ledr", {30'd0, LEDR}, 32'd1);
    check("found key", {8'd0, Secret_Key}, 32'd3);
    Checker_Finish = 1'b1;
    Key_Valid = 1'b0;
    repeat (3) @(negedge clk);
    Checker_Finish = 1'b0;
    @(negedge clk);
    check("found ign ack", {31'd0, Check_Ack}, 32'd0);
    check("found ign key", {8'd0, Secret_Key}, 32'd3);
    check("found ign vkf", {31'd0, Valid_Key_Found}, 32'd1);
    check("found no_cs", cs_count, 32'd4);
    check("found sb_empty", exp_keys.size(), 32'd0);

    // 6: reset during WAIT aborts, search restarts at key 0
    apply_reset();
    check("rerst vkf", {31'd0, Valid_Key_Found}, 32'd0);
    check("rerst ledr", {30'd0, LEDR}, 32'd0);
    start_search("restart");
    do_finish("rfail", 1'b0);
    expect_cs("rstep");
    apply_reset();
    check("midrst key", {8'd0, Secret_Key}, 32'd0);
    start_search("restart2");

    // 5: all six keys fail -> EXHAUSTED after key 5
    for (int i = 0; i < 5; i++) begin
      do_finish("exh", 1'b0);
      expect_cs("exh_step");
    end
    check("exh last_key", {8'd0, Secret_Key}, 32'd5);
    snap = cs_count;
    do_finish("exh_last", 1'b0);
    check("exh ledr", {30'd0, LEDR}, 32'd2);
    check("exh vkf", {31'd0, Valid_Key_Found}, 32'd0);
    repeat (4) @(negedge clk);
    check("exh no_cs", cs_count, snap);
    check("exh key_no_wrap", {8'd0, Secret_Key}, 32'd5);
    check("exh sb_empty", exp_keys.size(), 32'd0);

    // Valid verdict on the last key of the range: FOUND wins
    apply_reset();
    start_search("last");
    for (int i = 0; i < 5; i++) begin
      do_finish("last_f", 1'b0);
      expect_cs("last_step");
    end
    do_finish("last_valid", 1'b1);
    check("last ledr", {30'd0, LEDR}, 32'd1);
    check("last vkf", {31'd0, Valid_Key_Found}, 32'd1);
    check("last key", {8'd0, Secret_Key}, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
